// File: rtl/montgomery_exponent_selector_pkg.sv
// Shared types and sizing helpers for the Montgomery exponent selector.
// Optional last_out generation is controlled by MONT_SELECT_LAST_EN.
package mont_exp_pkg;

  localparam int unsigned STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_LOAD   = 2'd1;
  localparam state_t ST_STREAM = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  // Exponent blocks loaded per run.
  function automatic int unsigned exp_blocks_f(input int unsigned exp_bits,
                                               input int unsigned reg_size);
    return exp_bits / reg_size;
  endfunction

  // Counter width for a 0..n-1 counter, never narrower than one bit.
  function automatic int unsigned ctr_w_f(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/montgomery_exponent_selector_exponent_bit_register.sv
// Exponent register: block-indexed load, shift right on each completed square.
// Upper-bits zero-detect exists only when MONT_SELECT_LAST_EN is defined.
module exponent_bit_register
  import mont_exp_pkg::*;
#(
  parameter int unsigned REGISTER_SIZE = 32,
  parameter int unsigned EXP_BITS      = 2048
) (
  input  logic                                     clk_in,
  input  logic                                     rst_in,
  input  logic                                     clear_in,
  input  logic                                     load_in,
  input  logic [ctr_w_f(exp_blocks_f(EXP_BITS, REGISTER_SIZE))-1:0] load_idx_in,
  input  logic [REGISTER_SIZE-1:0]                 load_block_in,
  input  logic                                     shift_in,
  output logic                                     bit0_out,
  output logic                                     upper_zero_out
);

  localparam int unsigned EXP_BLOCKS = exp_blocks_f(EXP_BITS, REGISTER_SIZE);
  localparam int unsigned LW         = ctr_w_f(EXP_BLOCKS);

  logic [EXP_BITS-1:0] r_exp;

  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) begin
      r_exp <= '0;
    end else if (load_in) begin
      for (int unsigned k = 0; k < EXP_BLOCKS; k++) begin
        if (load_idx_in == LW'(k)) begin
          r_exp[k*REGISTER_SIZE +: REGISTER_SIZE] <= load_block_in;
        end
      end
    end else if (shift_in) begin
      r_exp <= {1'b0, r_exp[EXP_BITS-1:1]};
    end
  end

  assign bit0_out = r_exp[0];

`ifdef MONT_SELECT_LAST_EN
  assign upper_zero_out = (r_exp[EXP_BITS-1:1] == '0);
`else
  assign upper_zero_out = 1'b0;
`endif

endmodule

// File: rtl/montgomery_exponent_selector.sv
// Forwards the Montgomery squares whose exponent bit is set, with first/last framing.
// last_out is generated only when MONT_SELECT_LAST_EN is defined; otherwise it stays 0.
module montgomery_exponent_selector
  import mont_exp_pkg::*;
#(
  parameter int unsigned REGISTER_SIZE = 32,
  parameter int unsigned EXP_BITS      = 2048,
  parameter int unsigned SQUARE_BLOCKS = 128
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  input  logic [REGISTER_SIZE-1:0] exponent_block_in,
  input  logic                     exponent_valid_in,
  output logic                     consumed_exponent_out,
  input  logic [REGISTER_SIZE-1:0] square_block_in,
  input  logic                     square_valid_in,
  output logic [REGISTER_SIZE-1:0] selected_block_out,
  output logic                     selected_valid_out,
  output logic                     first_out,
  output logic                     last_out,
  output logic                     done_out,
  output logic                     zero_exp_out,
  output logic                     overrun_out
);

  localparam int unsigned EXP_BLOCKS = exp_blocks_f(EXP_BITS, REGISTER_SIZE);
  localparam int unsigned BW         = ctr_w_f(SQUARE_BLOCKS);
  localparam int unsigned SW         = ctr_w_f(EXP_BITS);
  localparam int unsigned LW         = ctr_w_f(EXP_BLOCKS);
  localparam logic [BW-1:0] BLK_LAST  = BW'(SQUARE_BLOCKS - 1);
  localparam logic [SW-1:0] SQ_LAST   = SW'(EXP_BITS - 1);
  localparam logic [LW-1:0] LOAD_LAST = LW'(EXP_BLOCKS - 1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [BW-1:0]            r_block_ctr;
  logic [SW-1:0]            r_square_ctr;
  logic [LW-1:0]            r_load_ctr;
  logic                     r_seen_first;
  logic [REGISTER_SIZE-1:0] r_sel_block;
  logic                     r_sel_valid;
  logic                     r_first;
  logic                     r_last;
  logic                     r_done;
  logic                     r_zero;
  logic                     r_overrun;

  logic w_load;
  logic w_fwd;
  logic w_first;
  logic w_wrap;
  logic w_final;
  logic w_bit0;
  logic w_upper_zero;

  exponent_bit_register #(
    .REGISTER_SIZE (REGISTER_SIZE),
    .EXP_BITS      (EXP_BITS)
  ) u_exp_reg (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .clear_in       (r_state == ST_IDLE),
    .load_in        (w_load),
    .load_idx_in    (r_load_ctr),
    .load_block_in  (exponent_block_in),
    .shift_in       (w_wrap),
    .bit0_out       (w_bit0),
    .upper_zero_out (w_upper_zero)
  );

  // Next-state and per-cycle strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_fwd       = 1'b0;
    w_first     = 1'b0;
    w_wrap      = 1'b0;
    w_final     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_in) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (exponent_valid_in) begin
          w_load = 1'b1;
          if (r_load_ctr == LOAD_LAST) w_state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (square_valid_in) begin
          w_fwd   = w_bit0;
          w_first = w_bit0 && (r_block_ctr == '0) && !r_seen_first;
          w_wrap  = (r_block_ctr == BLK_LAST);
          w_final = w_wrap && (r_square_ctr == SQ_LAST);
          if (w_final) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= ST_IDLE;
      r_block_ctr  <= '0;
      r_square_ctr <= '0;
      r_load_ctr   <= '0;
      r_seen_first <= 1'b0;
      r_sel_block  <= '0;
      r_sel_valid  <= 1'b0;
      r_first      <= 1'b0;
      r_last       <= 1'b0;
      r_done       <= 1'b0;
      r_zero       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE) begin
        r_block_ctr  <= '0;
        r_square_ctr <= '0;
        r_load_ctr   <= '0;
        r_seen_first <= 1'b0;
      end
      if (w_load) r_load_ctr <= r_load_ctr + LW'(1);
      if ((r_state == ST_STREAM) && square_valid_in) begin
        r_block_ctr <= w_wrap ? '0 : r_block_ctr + BW'(1);
        if (w_wrap) r_square_ctr <= r_square_ctr + SW'(1);
      end
      if (w_first) r_seen_first <= 1'b1;
      r_sel_valid <= w_fwd;
      r_sel_block <= w_fwd ? square_block_in : '0;
      r_first     <= w_first;
      r_last      <= w_fwd && w_wrap && w_upper_zero;
      r_done      <= w_final;
      // zero_exp reflects whether any block was selected, including the final one.
      r_zero      <= w_final && !(r_seen_first || w_first);
      if (square_valid_in && (r_state != ST_STREAM)) r_overrun <= 1'b1;
    end
  end

  assign consumed_exponent_out = w_load;
  assign selected_block_out    = r_sel_block;
  assign selected_valid_out    = r_sel_valid;
  assign first_out             = r_first;
  assign last_out              = r_last;
  assign done_out              = r_done;
  assign zero_exp_out          = r_zero;
  assign overrun_out           = r_overrun;

endmodule
